uart_tx: RTL and testbench

UART transmitter, the transmit-side partner of the existing UART receiver. Serialises 8-bit bytes LSb-first onto uart_txd as 1 start bit, 8 data bits and 1 or 2 stop bits, with no parity. Bit timing uses the same 16x-oversampled baud tick scheme as the receiver and shares its cfg_div and cfg_nstop configuration. A one-entry holding register sits in front of the shift register so a following byte can be queued while the current frame is on the line.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_baud.sv | 19 +
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: frame geometry, idle line level, FSM states.
package uart_pkg;
  localparam int   OVERSAMPLE    = 16;
  localparam int   DATA_BITS     = 8;
  localparam logic TX_IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_tx_baud.sv
// Baud tick generator: one tick every (cfg_div+1) clocks, restartable by clr.
module uart_tx_baud (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [15:0] cfg_div,
  input  logic        clr,
  output logic        baud_tick
);
  logic [15:0] cnt_q;

  assign baud_tick = (cnt_q == cfg_div);

  // Free-running divider; restarts on a frame load so the first bit is full length.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                cnt_q <= '0;
    else if (clr || baud_tick) cnt_q <= '0;
    else                       cnt_q <= cnt_q + 16'd1;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2, LSb first, 16x oversampled bit timing, one-byte holding register.
module uart_tx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic [15:0] cfg_div,
  input  logic        cfg_txen,
  input  logic        cfg_nstop,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        uart_txd
);
  tx_state_e   state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  data_cnt_q, data_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        nstop_q, nstop_d;

  logic baud_tick, bit_end, last_stop, load;

  uart_tx_baud u_baud (
    .clk       (clk),
    .rst_b     (rst_b),
    .cfg_div   (cfg_div),
    .clr       (load),
    .baud_tick (baud_tick)
  );

  assign tx_ready  = ~hold_full_q;
  assign tx_busy   = (state_q != IDLE);
  assign uart_txd  = txd_q;
  assign bit_end   = baud_tick && (tick_cnt_q == 4'(OVERSAMPLE - 1));
  assign last_stop = (stop_cnt_q == nstop_q);
  // A frame starts from IDLE, or straight out of the last stop bit for back-to-back bytes.
  assign load      = hold_full_q && cfg_txen &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end && last_stop));

  // Next-state, datapath and tx_done pulse.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    txd_d       = txd_q;
    tick_cnt_d  = (tx_busy && baud_tick) ? tick_cnt_q + 4'd1 : tick_cnt_q;
    data_cnt_d  = data_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    nstop_d     = nstop_q;
    tx_done     = 1'b0;

    // Write only lands in an empty holding register; never a same-cycle refill on load.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        txd_d      = TX_IDLE_LEVEL;
        tick_cnt_d = '0;
      end
      START: begin
        if (bit_end) begin
          state_d    = DATA;
          txd_d      = shift_q[0];
          data_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          data_cnt_d = data_cnt_q + 3'd1;
          if (data_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d    = STOP;
            txd_d      = TX_IDLE_LEVEL;
            stop_cnt_d = 1'b0;
            nstop_d    = cfg_nstop;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            tx_done = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d     = START;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      txd_d       = ~TX_IDLE_LEVEL;
      tick_cnt_d  = '0;
      data_cnt_d  = '0;
    end
  end

  // State and datapath registers; reset drops any frame and queued byte.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      txd_q       <= TX_IDLE_LEVEL;
      tick_cnt_q  <= '0;
      data_cnt_q  <= '0;
      stop_cnt_q  <= 1'b0;
      nstop_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
      tick_cnt_q  <= tick_cnt_d;
      data_cnt_q  <= data_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      nstop_q     <= nstop_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, divider, back-to-back, enable gating, reset, loopback-style decode.
module tb_uart_tx;
  logic        clk = 1'b0;
  logic        rst_b;
  logic [15:0] cfg_div;
  logic        cfg_txen, cfg_nstop, tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, tx_busy, tx_done, uart_txd;

  int n_chk = 0;
  int n_fail = 0;

  uart_tx dut (
    .clk(clk), .rst_b(rst_b), .cfg_div(cfg_div), .cfg_txen(cfg_txen),
    .cfg_nstop(cfg_nstop), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write is seen by the next posedge. Returns at the following negedge.
  task automatic write_byte(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Called at the negedge just after the load edge (sample index 0). Checks every bit level
  // over its whole period and the single tx_done in the last cycle; returns at index total.
  task automatic check_frame(input string nm, input logic [7:0] d, input int div, input int nstop);
    int bp, total, dcnt, dpos, b;
    int match [11];
    logic e;
    bp = 16 * (div + 1);
    total = (10 + nstop) * bp;
    dcnt = 0;
    dpos = -1;
    for (int k = 0; k < 11; k++) match[k] = 0;
    for (int i = 0; i < total; i++) begin
      b = i / bp;
      if (b == 0)      e = 1'b0;
      else if (b <= 8) e = d[b-1];
      else             e = 1'b1;
      if (uart_txd === e) match[b]++;
      if (tx_done === 1'b1) begin dcnt++; dpos = i; end
      @(negedge clk);
    end
    for (int k = 0; k < 10 + nstop; k++) chk($sformatf("%s_bit%0d", nm, k), match[k], bp);
    chk({nm, "_done_cnt"}, dcnt, 1);
    chk({nm, "_done_pos"}, dpos, total - 1);
  endtask

  initial begin
    logic [7:0] rb;
    rst_b = 1'b0; cfg_div = 16'd0; cfg_txen = 1'b1; cfg_nstop = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1); chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0); chk("rst_done", tx_done, 0);
    rst_b = 1'b1;
    @(negedge clk);

    // Single frame 0x55, div 0, one stop bit; latency write -> hold -> start.
    write_byte(8'h55);
    chk("lat_ready", tx_ready, 0); chk("lat_txd", uart_txd, 1); chk("lat_busy", tx_busy, 0);
    @(negedge clk);
    chk("start_txd", uart_txd, 0); chk("start_busy", tx_busy, 1); chk("start_ready", tx_ready, 1);
    check_frame("f55", 8'h55, 0, 0);
    chk("f55_busy_end", tx_busy, 0); chk("f55_txd_end", uart_txd, 1);

    // Divider 3: 64-cycle bits, LSb first.
    cfg_div = 16'd3;
    write_byte(8'h01);
    @(negedge clk);
    check_frame("f01", 8'h01, 3, 0);
    chk("f01_busy_end", tx_busy, 0);

    // Back-to-back, two stop bits; second byte queued while the first is in DATA.
    cfg_div = 16'd0; cfg_nstop = 1'b1;
    write_byte(8'hA5);
    chk("b2b_ready0", tx_ready, 0);
    @(negedge clk);
    fork
      check_frame("fA5", 8'hA5, 0, 1);
      begin
        repeat (40) @(negedge clk);
        chk("b2b_ready1", tx_ready, 1);
        write_byte(8'h3C);
        chk("b2b_ready2", tx_ready, 0);
      end
    join
    chk("b2b_start_txd", uart_txd, 0); chk("b2b_busy", tx_busy, 1);
    chk("b2b_ready3", tx_ready, 1);
    check_frame("f3C", 8'h3C, 0, 1);
    chk("f3C_busy_end", tx_busy, 0);

    // Enable gating: byte held while disabled, starts one cycle after enabling.
    cfg_nstop = 1'b0; cfg_txen = 1'b0;
    write_byte(8'h7E);
    begin
      int hi = 0, bz = 0;
      for (int i = 0; i < 500; i++) begin
        if (uart_txd === 1'b1) hi++;
        if (tx_busy === 1'b1) bz++;
        @(negedge clk);
      end
      chk("gate_txd_hi", hi, 500); chk("gate_busy", bz, 0); chk("gate_ready", tx_ready, 0);
    end
    cfg_txen = 1'b1;
    @(negedge clk);
    chk("gate_start", uart_txd, 0);
    check_frame("f7E", 8'h7E, 0, 0);

    // Reset during data bit 3 with a byte queued: all cleared, queued byte lost.
    write_byte(8'hFF);
    @(negedge clk);
    write_byte(8'h00);
    repeat (16 * 4 + 8 - 1) @(negedge clk);
    chk("rstm_txd_pre", uart_txd, 1);
    rst_b = 1'b0;
    #1;
    chk("rstm_txd", uart_txd, 1); chk("rstm_ready", tx_ready, 1); chk("rstm_busy", tx_busy, 0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (40) @(negedge clk);
    chk("rstm_lost", uart_txd + {tx_busy, 1'b0}, 1);
    write_byte(8'h81);
    @(negedge clk);
    check_frame("f81", 8'h81, 0, 0);

    // Decoded frames at div 5 with both stop settings, then random bytes at div 0.
    cfg_div = 16'd5;
    for (int j = 0; j < 3; j++) begin
      rb = (j == 0) ? 8'h00 : (j == 1) ? 8'hFF : 8'hC3;
      cfg_nstop = j[0];
      write_byte(rb);
      @(negedge clk);
      check_frame($sformatf("lb%0d", j), rb, 5, j % 2);
    end
    cfg_div = 16'd0;
    for (int j = 0; j < 12; j++) begin
      rb = 8'($urandom_range(0, 255));
      cfg_nstop = j[1];
      write_byte(rb);
      @(negedge clk);
      check_frame($sformatf("rnd%0d", j), rb, 0, (j / 2) % 2);
    end
    chk("final_busy", tx_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
